// File: rtl/stream_sum.sv
// stream_sum: accumulates a handshaked two's-complement stream into a wrapping sum and a saturating count.
module stream_sum #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  input  logic         sIn_last,
  output logic [N-1:0] dOut,
  output logic [N-1:0] cOut
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] cnt_q, cnt_d;
  // Outputs are forced to their idle values while reset is held, not just after the edge.
  assign in_ready  = !nRST || state_q == IDLE;
  assign sIn_ready = nRST && state_q == COLLECT;
  assign out_valid = nRST && state_q == DONE;
  assign dOut      = nRST ? acc_q : '0;
  assign cOut      = nRST ? cnt_q : '0;
  always_comb begin
    state_d = (state_q == 2'd3) ? IDLE : state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (in_valid && in_ready) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = COLLECT;
    end
    if (sIn_valid && sIn_ready) begin
      acc_d   = acc_q + sIn;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + N'(1);
      state_d = sIn_last ? DONE : state_d;
    end
    if (out_valid && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_sum.sv
// tb_stream_sum: directed vectors with hand-computed sums and counts for stream_sum.
module tb_stream_sum;
  logic       clk = 0;
  logic       nRST;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] sIn, dOut, cOut;
  logic       sIn_valid, sIn_ready, sIn_last;
  int         n_chk = 0;
  int         n_err = 0;

  stream_sum #(.N(8)) dut (
    .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .sIn(sIn),
    .sIn_valid(sIn_valid), .sIn_ready(sIn_ready), .sIn_last(sIn_last),
    .dOut(dOut), .cOut(cOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start;
    in_valid = 1;
    tick;
    in_valid = 0;
  endtask

  task automatic beat(input logic [7:0] v, input logic last);
    sIn = v; sIn_valid = 1; sIn_last = last;
    tick;
    sIn_valid = 0; sIn_last = 0;
  endtask

  task automatic consume;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  task automatic result(input string tag, input logic [7:0] d, input logic [7:0] c);
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_d"}, dOut, d);
    chk({tag, "_c"}, cOut, c);
  endtask

  initial begin
    nRST = 0; in_valid = 0; out_ready = 0; sIn = 0; sIn_valid = 0; sIn_last = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sin_ready", sIn_ready, 0);
    chk("rst_dout", dOut, 0);
    chk("rst_cout", cOut, 0);
    tick; tick;
    nRST = 1;
    tick;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // 3,5,7 back to back, result held until consumed
    start;
    chk("collect_sin_ready", sIn_ready, 1);
    chk("collect_in_ready", in_ready, 0);
    beat(3, 0); beat(5, 0); beat(7, 1);
    result("r357", 15, 3);
    chk("done_sin_ready", sIn_ready, 0);
    tick; tick;
    result("r357_hold", 15, 3);
    consume;
    chk("r357_idle", in_ready, 1);
    chk("r357_ov_drop", out_valid, 0);

    start; beat(1, 1);
    result("single", 1, 1);
    consume;

    start; beat(200, 0); beat(100, 1);
    result("wrap", 44, 2);
    consume;

    start; beat(8'hFF, 0); beat(8'hFF, 1);
    result("neg", 8'hFE, 2);
    consume;

    // gapped stream, stray sIn_last and out_ready during COLLECT ignored
    start;
    beat(1, 0);
    sIn_last = 1; tick; sIn_last = 0;
    chk("gap_last_ignored", sIn_ready, 1);
    out_ready = 1; tick; out_ready = 0;
    chk("gap_oready_ignored", sIn_ready, 1);
    chk("gap_running_c", cOut, 1);
    beat(2, 0);
    tick;
    beat(4, 1);
    for (int i = 0; i < 5; i++) begin
      result($sformatf("gap_hold%0d", i), 7, 3);
      tick;
    end
    consume;
    chk("gap_idle", in_ready, 1);

    // reset mid-COLLECT discards the stream
    start; beat(9, 0); beat(9, 0);
    chk("run_d", dOut, 18);
    chk("run_c", cOut, 2);
    nRST = 0; tick; nRST = 1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sin_ready", sIn_ready, 0);
    chk("midrst_d", dOut, 0);
    chk("midrst_c", cOut, 0);
    tick;
    chk("midrst_no_ov", out_valid, 0);
    start; beat(2, 1);
    result("after_rst", 2, 1);
    consume;

    // reset in DONE drops the result
    start; beat(5, 1);
    nRST = 0; tick; nRST = 1;
    chk("donerst_ov", out_valid, 0);
    chk("donerst_d", dOut, 0);

    // in_valid held, sIn_valid in DONE/IDLE not accepted
    in_valid = 1;
    tick;
    beat(3, 0); beat(4, 1);
    chk("hold_done_in_ready", in_ready, 0);
    sIn = 50; sIn_valid = 1;
    tick;
    result("hold_done", 7, 2);
    consume;
    chk("hold_idle_in_ready", in_ready, 1);
    chk("hold_idle_sin_ready", sIn_ready, 0);
    tick;
    chk("hold_restart_d", dOut, 0);
    chk("hold_restart_c", cOut, 0);
    chk("hold_restart_sin_ready", sIn_ready, 1);
    sIn_valid = 0; in_valid = 0;
    beat(6, 1);
    result("hold_second", 6, 1);
    consume;

    // 300 ones: sum wraps to 44, count saturates at 255
    start;
    for (int i = 0; i < 299; i++) beat(1, 0);
    beat(1, 1);
    result("sat", 44, 255);
    consume;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
